// File: rtl/axis_packet_master.sv
// axis_packet_master: pops beats from a show-ahead FIFO, frames them into packets
// (tuser on the first beat, tlast/tkeep on the last) and drives an AXI4-Stream
// master through a two-entry output/skid buffer. fifo_ready is a flop, so there
// is no combinational path from m_axis_tready back to the FIFO.
module axis_packet_master #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned LEN_WIDTH  = 16,
    parameter int unsigned KEEP_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    input  logic                  fifo_valid,
    output logic                  fifo_ready,
    input  logic                  enable,
    input  logic [LEN_WIDTH-1:0]  cfg_pkt_len,
    input  logic [KEEP_WIDTH-1:0] cfg_last_keep,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tuser,
    output logic                  busy,
    output logic [31:0]           pkt_count
);

    localparam int unsigned CNT_WIDTH = 32;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    // One buffered beat: payload plus the framing computed at ingress
    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [KEEP_WIDTH-1:0] keep;
        logic                  last;
        logic                  user;
    } beat_t;

    state_e                state_q, state_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [KEEP_WIDTH-1:0] keep_q, keep_d;
    logic [LEN_WIDTH-1:0]  idx_q, idx_d;
    beat_t                 out_q, out_d;
    logic                  out_valid_q, out_valid_d;
    beat_t                 skid_q, skid_d;
    logic                  skid_valid_q, skid_valid_d;
    logic                  fifo_ready_q, fifo_ready_d;
    logic                  busy_q, busy_d;
    logic [CNT_WIDTH-1:0]  pkt_count_q, pkt_count_d;

    logic                  accept;
    logic                  drain;
    logic                  in_last;
    beat_t                 in_beat;

    // Handshake strobes and ingress framing for the beat at the FIFO head
    assign accept       = fifo_valid && fifo_ready_q;
    assign drain        = out_valid_q && m_axis_tready;
    assign in_last      = (idx_q == (len_q - LEN_WIDTH'(1)));
    assign in_beat.data = fifo_data;
    assign in_beat.keep = in_last ? keep_q : {KEEP_WIDTH{1'b1}};
    assign in_beat.last = in_last;
    assign in_beat.user = (idx_q == '0);

    // Next-state: packet FSM, beat index, buffer steering and status
    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        keep_d       = keep_q;
        idx_d        = idx_q;
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        pkt_count_d  = pkt_count_q;

        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    state_d = S_RUN;
                    len_d   = (cfg_pkt_len == '0) ? LEN_WIDTH'(1) : cfg_pkt_len;
                    keep_d  = (cfg_last_keep == '0) ? {KEEP_WIDTH{1'b1}} : cfg_last_keep;
                    idx_d   = '0;
                end
            end
            S_RUN: begin
                if (accept) begin
                    if (in_last) begin
                        idx_d = '0;
                        if (enable) begin
                            len_d  = (cfg_pkt_len == '0) ? LEN_WIDTH'(1) : cfg_pkt_len;
                            keep_d = (cfg_last_keep == '0) ? {KEEP_WIDTH{1'b1}} : cfg_last_keep;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        idx_d = idx_q + LEN_WIDTH'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // OUT refills from SKID first; a new beat lands in SKID only when OUT is stalled
        if (!out_valid_q || drain) begin
            if (skid_valid_q) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                out_d       = in_beat;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_d       = in_beat;
            skid_valid_d = 1'b1;
        end

        if (drain && out_q.last) begin
            pkt_count_d = pkt_count_q + CNT_WIDTH'(1);
        end

        // Ready only while running and SKID is free; held low on the IDLE->RUN entry cycle
        fifo_ready_d = (state_q == S_RUN) && (state_d == S_RUN) && !skid_valid_d;
        busy_d       = (state_d == S_RUN) || out_valid_d || skid_valid_d;
    end

    // State and buffer registers
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q      <= S_IDLE;
            len_q        <= LEN_WIDTH'(1);
            keep_q       <= {KEEP_WIDTH{1'b1}};
            idx_q        <= '0;
            out_q        <= '0;
            out_valid_q  <= 1'b0;
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
            fifo_ready_q <= 1'b0;
            busy_q       <= 1'b0;
            pkt_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            keep_q       <= keep_d;
            idx_q        <= idx_d;
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
            fifo_ready_q <= fifo_ready_d;
            busy_q       <= busy_d;
            pkt_count_q  <= pkt_count_d;
        end
    end

    assign fifo_ready    = fifo_ready_q;
    assign m_axis_tdata  = out_q.data;
    assign m_axis_tkeep  = out_q.keep;
    assign m_axis_tlast  = out_q.last;
    assign m_axis_tuser  = out_q.user;
    assign m_axis_tvalid = out_valid_q;
    assign busy          = busy_q;
    assign pkt_count     = pkt_count_q;

endmodule

// File: tb/tb_axis_packet_master.sv
// Bench for axis_packet_master: a FIFO model feeds words, a packet-level model
// queues the expected framed beats, and a monitor pops and compares each output beat.
module tb_axis_packet_master;

    localparam int unsigned DW = 64;
    localparam int unsigned LW = 16;
    localparam int unsigned KW = DW / 8;

    logic          aclk = 1'b0;
    logic          areset;
    logic [DW-1:0] fifo_data;
    logic          fifo_valid;
    logic          fifo_ready;
    logic          enable;
    logic [LW-1:0] cfg_pkt_len;
    logic [KW-1:0] cfg_last_keep;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic          m_axis_tlast;
    logic [KW-1:0] m_axis_tkeep;
    logic          m_axis_tuser;
    logic          busy;
    logic [31:0]   pkt_count;

    axis_packet_master #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .aclk          (aclk),
        .areset        (areset),
        .fifo_data     (fifo_data),
        .fifo_valid    (fifo_valid),
        .fifo_ready    (fifo_ready),
        .enable        (enable),
        .cfg_pkt_len   (cfg_pkt_len),
        .cfg_last_keep (cfg_last_keep),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tuser  (m_axis_tuser),
        .busy          (busy),
        .pkt_count     (pkt_count)
    );

    always #5 aclk = ~aclk;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic          l;
        logic          u;
    } beat_t;

    beat_t         exp_q[$];
    logic [DW-1:0] fifo_q[$];

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int acc_cnt = 0, out_cnt = 0, acc_tot = 0, out_tot = 0;
    int first_acc = -1, first_out = -1, last_out = -1;
    int vpct = 100, rpct = 100, drop_at = 0, chg_at = -1;
    logic [LW-1:0] chg_len = '0;
    bit drv_en = 1'b0;
    int exp_pkts = 0;

    bit    stall_pending = 1'b0;
    beat_t held;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_chk++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %0h want %0h", name, act, expv);
    endtask

    always @(posedge aclk) cyc++;

    // FIFO and sink driver: updates inputs just after each active edge
    always @(posedge aclk) begin
        #1;
        if (drv_en) begin
            fifo_valid    = (fifo_q.size() > 0) && (int'($urandom_range(99)) < vpct);
            fifo_data     = fifo_valid ? fifo_q[0] : {$urandom, $urandom};
            m_axis_tready = int'($urandom_range(99)) < rpct;
            if (drop_at > 0 && acc_cnt >= drop_at) enable = 1'b0;
            if (chg_at >= 0 && acc_cnt >= chg_at) cfg_pkt_len = chg_len;
        end
    end

    // Monitor: handshakes seen here commit at the next rising edge
    always @(negedge aclk) begin
        beat_t got, e;
        if (areset) begin
            stall_pending = 1'b0;
        end else begin
            got = {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser};
            if (acc_tot - out_tot >= 2) chk("ready_with_buffer_full", 64'(fifo_ready), 64'd0);
            if (stall_pending) begin
                n_chk++;
                if (m_axis_tvalid && got === held) n_pass++;
                else $display("FAIL stall_stable: got v=%b %h want v=1 %h", m_axis_tvalid, got, held);
            end
            if (m_axis_tvalid && m_axis_tready) begin
                n_chk++;
                if (exp_q.size() == 0) begin
                    $display("FAIL unexpected_beat: got d=%h with nothing expected", m_axis_tdata);
                end else begin
                    e = exp_q.pop_front();
                    if (got === e) n_pass++;
                    else $display("FAIL beat: got d=%h k=%h l=%b u=%b want d=%h k=%h l=%b u=%b",
                                  got.d, got.k, got.l, got.u, e.d, e.k, e.l, e.u);
                end
                out_cnt++;
                out_tot++;
                if (first_out < 0) first_out = cyc;
                last_out = cyc;
            end
            stall_pending = m_axis_tvalid && !m_axis_tready;
            held = got;
            if (fifo_valid && fifo_ready) begin
                if (fifo_q.size() > 0) void'(fifo_q.pop_front());
                acc_cnt++;
                acc_tot++;
                if (first_acc < 0) first_acc = cyc;
            end
        end
    end

    function automatic int eff_len(input int len);
        return (len == 0) ? 1 : len;
    endfunction

    // One scenario: load words, model expected framing, run, then check end state
    task automatic run_test(input string tag, input int len, input int keep, input int nwords,
                            input int extra, input int vp, input int rp, input int dropat,
                            input int chgat, input int newlen, input bit rnd, input int base,
                            input bit lat_chk);
        logic [DW-1:0] w;
        logic [KW-1:0] ekeep;
        int pos, curlen, waited;
        beat_t b;
        fifo_q.delete();
        exp_q.delete();
        acc_cnt = 0; out_cnt = 0; first_acc = -1; first_out = -1; last_out = -1;
        ekeep = (keep == 0) ? {KW{1'b1}} : KW'(keep);
        pos = 0;
        curlen = eff_len(len);
        for (int i = 0; i < nwords + extra; i++) begin
            w = rnd ? {$urandom, $urandom} : DW'(base + i);
            fifo_q.push_back(w);
            if (i < nwords) begin
                if (pos == 0) curlen = (chgat >= 0 && i > chgat) ? eff_len(newlen) : eff_len(len);
                b.d = w;
                b.u = (pos == 0);
                b.l = (pos == curlen - 1);
                b.k = b.l ? ekeep : {KW{1'b1}};
                exp_q.push_back(b);
                if (b.l) begin
                    exp_pkts++;
                    pos = 0;
                end else begin
                    pos++;
                end
            end
        end
        cfg_pkt_len = LW'(len);
        cfg_last_keep = KW'(keep);
        vpct = vp; rpct = rp; drop_at = dropat; chg_at = chgat; chg_len = LW'(newlen);
        @(posedge aclk);
        drv_en = 1'b1;
        #1;
        enable = 1'b1;
        if (lat_chk) begin
            @(negedge aclk);
            @(negedge aclk);
            chk({tag, "_ready_not_yet"}, 64'(fifo_ready), 64'd0);
            @(negedge aclk);
            chk({tag, "_ready_after_2"}, 64'(fifo_ready), 64'd1);
        end
        waited = 0;
        while (!(exp_q.size() == 0 && !busy && acc_cnt >= nwords) && waited < 4000) begin
            @(negedge aclk);
            waited++;
        end
        chk({tag, "_completed"}, 64'(waited < 4000), 64'd1);
        chk({tag, "_pkt_count"}, 64'(pkt_count), 64'(exp_pkts));
        chk({tag, "_fifo_left"}, 64'(fifo_q.size()), 64'(extra));
        chk({tag, "_ready_idle"}, 64'(fifo_ready), 64'd0);
        chk({tag, "_busy_idle"}, 64'(busy), 64'd0);
        if (lat_chk) begin
            chk({tag, "_latency"}, 64'(first_out - first_acc), 64'd1);
            chk({tag, "_throughput"}, 64'(last_out - first_out), 64'(nwords - 1));
        end
        drv_en = 1'b0;
        chg_at = -1;
        fifo_valid = 1'b0;
        fifo_q.delete();
        exp_q.delete();
        @(negedge aclk);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_tvalid"}, 64'(m_axis_tvalid), 64'd0);
        chk({tag, "_tdata"}, 64'(m_axis_tdata), 64'd0);
        chk({tag, "_tlast"}, 64'(m_axis_tlast), 64'd0);
        chk({tag, "_tuser"}, 64'(m_axis_tuser), 64'd0);
        chk({tag, "_tkeep"}, 64'(m_axis_tkeep), 64'd0);
        chk({tag, "_fifo_ready"}, 64'(fifo_ready), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_pkt_count"}, 64'(pkt_count), 64'd0);
    endtask

    initial begin
        int len, np, n, keep, waited;
        areset = 1'b1;
        enable = 1'b0;
        fifo_valid = 1'b0;
        fifo_data = '0;
        m_axis_tready = 1'b0;
        cfg_pkt_len = '0;
        cfg_last_keep = '0;
        repeat (3) @(posedge aclk);
        #2;
        check_reset_values("reset");
        @(negedge aclk);
        #2 areset = 1'b0;
        @(negedge aclk);
        check_reset_values("post_release");

        // Two 4-beat packets at full rate
        run_test("basic", 4, 'h0F, 8, 0, 100, 100, 7, -1, 0, 1'b0, 0, 1'b1);
        // Same words under random backpressure
        run_test("bp", 4, 'h0F, 8, 0, 100, 50, 7, -1, 0, 1'b0, 0, 1'b0);
        // Enable dropped mid-packet: packet completes, remaining words stay in the FIFO
        run_test("en_drop", 5, 'h03, 5, 3, 80, 70, 3, -1, 0, 1'b0, 'h100, 1'b0);
        // Zero length and zero keep map to 1-beat packets with full keep
        run_test("len0", 0, 0, 3, 0, 100, 100, 2, -1, 0, 1'b0, 'h200, 1'b0);
        // Length changed mid-packet only affects the next packet
        run_test("cfg_chg", 3, 'h01, 5, 0, 90, 60, 4, 1, 2, 1'b0, 'h300, 1'b0);

        for (int it = 0; it < 6; it++) begin
            len = int'($urandom_range(6));
            np = int'($urandom_range(1, 4));
            n = np * eff_len(len);
            if (n < 2) n = 2 * eff_len(len);
            keep = ($urandom_range(3) == 0) ? 0 : int'($urandom_range(255));
            run_test("rand", len, keep, n, 0, int'($urandom_range(30, 100)),
                     int'($urandom_range(30, 100)), n - 1, -1, 0, 1'b1, 0, 1'b0);
        end

        // Reset with OUT and SKID both full partway through a packet
        fifo_q.delete();
        exp_q.delete();
        acc_cnt = 0;
        for (int i = 0; i < 6; i++) fifo_q.push_back(DW'('h400 + i));
        cfg_pkt_len = LW'(6);
        cfg_last_keep = '0;
        vpct = 100; rpct = 0; drop_at = 0; chg_at = -1;
        @(posedge aclk);
        drv_en = 1'b1;
        #1 enable = 1'b1;
        waited = 0;
        while (acc_cnt < 2 && waited < 50) begin
            @(negedge aclk);
            waited++;
        end
        chk("rst_fill_done", 64'(acc_cnt >= 2), 64'd1);
        @(negedge aclk);
        chk("rst_busy_before", 64'(busy), 64'd1);
        chk("rst_tvalid_before", 64'(m_axis_tvalid), 64'd1);
        @(posedge aclk);
        #3 areset = 1'b1;
        #1;
        drv_en = 1'b0;
        enable = 1'b0;
        fifo_valid = 1'b0;
        m_axis_tready = 1'b0;
        fifo_q.delete();
        exp_q.delete();
        acc_cnt = 0; acc_tot = 0; out_cnt = 0; out_tot = 0;
        exp_pkts = 0;
        check_reset_values("mid_rst");
        @(negedge aclk);
        #2 areset = 1'b0;
        @(negedge aclk);
        chk("after_rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        run_test("post_rst", 3, 'h07, 6, 0, 100, 80, 5, -1, 0, 1'b0, 'h500, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
